// File: rtl/fft_bitrev_reorder_pkg.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder_pkg
// Shared types and helpers for the FFT bit-reverse reorder block.
//   DATA_WIDTH     : width of each of data_r / data_i
//   MAX_LOG2N      : widest bit-reverse the helper function supports
//   fft_data_t     : one complex sample {data_r, data_i}
//   fft_data_bus_t : streaming bus {valid, data}
//   bitrev()       : reverse the low 'width' bits of a value
// -----------------------------------------------------------------------------
package fft_bitrev_reorder_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int MAX_LOG2N  = 16;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data_r;
        logic [DATA_WIDTH-1:0] data_i;
    } fft_data_t;

    typedef struct packed {
        logic      valid;
        fft_data_t data;
    } fft_data_bus_t;

    // Reverses the low 'width' bits of 'value'; bits at or above 'width'
    // come back as zero. Built by shifting so no variable bit index is needed.
    function automatic logic [MAX_LOG2N-1:0] bitrev(
        input logic [MAX_LOG2N-1:0] value,
        input int                   width
    );
        logic [MAX_LOG2N-1:0] result;
        logic [MAX_LOG2N-1:0] remaining;
        result    = '0;
        remaining = value;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            if (i < width) begin
                result    = {result[MAX_LOG2N-2:0], remaining[0]};
                remaining = remaining >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder_ram (ping-pong sample store)
// Two banks of 2**ADDR_W complex samples, addressed as {bank, addr}.
// One write port, one combinational read port: the read value feeds the
// top's output register directly, so the register itself is the only
// pipeline stage on the read side.
//   clk    : clock, write on rising edge
//   we     : write enable
//   waddr  : {bank, addr} write address
//   wdata  : sample to store
//   raddr  : {bank, addr} read address
//   rdata  : sample at raddr (combinational)
// -----------------------------------------------------------------------------
module fft_pingpong_ram
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int ADDR_W = 6
)
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W:0]   waddr,
    input  fft_data_t         wdata,
    input  logic [ADDR_W:0]   raddr,
    output fft_data_t         rdata
);

    localparam int DEPTH = 2 << ADDR_W;

    fft_data_t mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder
// Takes a frame stream in bit-reversed order and re-emits it in natural
// order using two ping-pong banks: one bank fills while the other drains.
// Each incoming sample is written at the bit-reversed address of its arrival
// position, so the drain side simply reads addresses 0..N-1 in sequence.
//   clk        : clock, all state on rising edge
//   rst_n      : synchronous active-low reset
//   in         : {valid, data} input stream (bit-reversed order)
//   ready      : block can accept 'in' this cycle
//   out        : {valid, data} natural-order stream, data = 0 when not valid
//   next_ready : downstream accepts 'out' this cycle
// -----------------------------------------------------------------------------
module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int LOG2N = 6
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  fft_data_bus_t in,
    output logic          ready,
    output fft_data_bus_t out,
    input  logic          next_ready
);

    // Write side state
    logic [LOG2N-1:0] wcnt_reg;
    logic [LOG2N-1:0] wcnt_next;
    logic             wbank_reg;
    logic             wbank_next;

    // Read side state
    logic [LOG2N-1:0] rcnt_reg;
    logic [LOG2N-1:0] rcnt_next;
    logic             rbank_reg;
    logic             rbank_next;

    // One flag per bank: set when the bank holds a complete frame,
    // cleared when its last sample has been loaded into the output register.
    logic [1:0]       full_reg;
    logic [1:0]       full_next;

    fft_data_bus_t    out_reg;
    fft_data_bus_t    out_next;

    logic             accept;
    logic             load;
    logic             wr_last;
    logic             rd_last;
    logic [LOG2N-1:0] wr_addr;
    fft_data_t        rd_data;

    // ready depends only on registered state, never on in.valid, so there is
    // no combinational path from upstream valid back to upstream ready.
    assign ready   = ~full_reg[wbank_reg];
    assign accept  = in.valid & ready;

    // The output register reloads whenever it is empty or being consumed.
    assign load    = full_reg[rbank_reg] & (~out_reg.valid | next_ready);

    assign wr_last = accept & (wcnt_reg == '1);
    assign rd_last = load & (rcnt_reg == '1);

    assign wr_addr = LOG2N'(bitrev(MAX_LOG2N'(wcnt_reg), LOG2N));

    fft_pingpong_ram #(
        .ADDR_W (LOG2N)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr ({wbank_reg, wr_addr}),
        .wdata (in.data),
        .raddr ({rbank_reg, rcnt_reg}),
        .rdata (rd_data)
    );

    always_comb begin
        wcnt_next  = wcnt_reg;
        wbank_next = wbank_reg;
        rcnt_next  = rcnt_reg;
        rbank_next = rbank_reg;
        full_next  = full_reg;
        out_next   = out_reg;

        if (accept) begin
            // Counter is LOG2N bits wide, so the last sample wraps it to 0.
            wcnt_next = wcnt_reg + 1'b1;
            if (wr_last) begin
                wbank_next = ~wbank_reg;
            end
        end

        if (load) begin
            rcnt_next      = rcnt_reg + 1'b1;
            out_next.valid = 1'b1;
            out_next.data  = rd_data;
            if (rd_last) begin
                rbank_next = ~rbank_reg;
            end
        end else if (next_ready && out_reg.valid) begin
            out_next = '0;
        end

        // A bank being completed is always the write bank (not full) and a
        // bank being released is always the read bank (full), so these two
        // updates never target the same flag.
        if (wr_last) begin
            full_next[wbank_reg] = 1'b1;
        end
        if (rd_last) begin
            full_next[rbank_reg] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_reg  <= '0;
            wbank_reg <= 1'b0;
            rcnt_reg  <= '0;
            rbank_reg <= 1'b0;
            full_reg  <= '0;
            out_reg   <= '0;
        end else begin
            wcnt_reg  <= wcnt_next;
            wbank_reg <= wbank_next;
            rcnt_reg  <= rcnt_next;
            rbank_reg <= rbank_next;
            full_reg  <= full_next;
            out_reg   <= out_next;
        end
    end

    assign out = out_reg;

endmodule
